// File: rtl/shift_chain_ctrl.sv
// shift_chain_ctrl: frame controller for a serial chain of capture stages.
// Accepts a WIDTH-bit word over valid/ready, shifts it MSB-first out on sdo
// while sampling the chain tail on sdi, then pulses latch/rd_valid once.
// Static mode sends one frame per word; dynamic mode re-sends the held word.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   load_valid/ready    word handshake; ready only while IDLE
//   load_data[WIDTH]    word to shift into the chain
//   mode_dyn            0=static, 1=dynamic re-send (sampled in IDLE only)
//   sdo, shift_en       serial data to chain head and stage-advance enable
//   sdi                 serial data from chain tail
//   latch               one-cycle update strobe to chain outputs
//   rd_data, rd_valid   readback of previous chain contents, one-cycle valid
//   busy                controller is not IDLE
module shift_chain_ctrl #(
  parameter int WIDTH = 16,
  parameter int GAP   = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             mode_dyn,
  output logic             sdo,
  output logic             shift_en,
  input  logic             sdi,
  output logic             latch,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LATCH = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  localparam int CW       = $clog2(WIDTH);
  localparam int GW       = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;
  localparam logic [CW-1:0] CNT_LAST  = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GCNT_LAST = GW'(GAP_LAST);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic             have_word_q, have_word_d;
  logic             sdo_q, sdo_d;
  logic             shift_en_q, shift_en_d;
  logic             latch_q, latch_d;
  logic             rd_valid_q, rd_valid_d;

  logic             start;
  logic [WIDTH-1:0] start_word;
  logic [WIDTH-1:0] rx_next;

  // A fresh word always wins over a dynamic re-send of the held word.
  assign start      = (state_q == S_IDLE) && (load_valid || (mode_dyn && have_word_q));
  assign start_word = load_valid ? load_data : hold_q;
  assign rx_next    = {rx_q[WIDTH-2:0], sdi};

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      sreg_q      <= '0;
      rx_q        <= '0;
      hold_q      <= '0;
      rd_data_q   <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      have_word_q <= 1'b0;
      sdo_q       <= 1'b0;
      shift_en_q  <= 1'b0;
      latch_q     <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      rx_q        <= rx_d;
      hold_q      <= hold_d;
      rd_data_q   <= rd_data_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      have_word_q <= have_word_d;
      sdo_q       <= sdo_d;
      shift_en_q  <= shift_en_d;
      latch_q     <= latch_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SHIFT;
      S_SHIFT: if (bit_cnt_q == CNT_LAST) state_d = S_LATCH;
      S_LATCH: begin
        if (GAP > 0) state_d = S_GAP;
        else         state_d = S_IDLE;
      end
      S_GAP:   if (gap_cnt_q == GCNT_LAST) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs and datapath. Strobes are computed one cycle ahead so
  // that they line up with the state they belong to.
  always_comb begin
    sreg_d      = sreg_q;
    rx_d        = rx_q;
    hold_d      = hold_q;
    rd_data_d   = rd_data_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    have_word_d = have_word_q;
    sdo_d       = 1'b0;
    shift_en_d  = 1'b0;
    latch_d     = 1'b0;
    rd_valid_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sreg_d     = start_word;
          sdo_d      = start_word[WIDTH-1];
          shift_en_d = 1'b1;
          bit_cnt_d  = '0;
          if (load_valid) begin
            hold_d      = load_data;
            have_word_d = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        rx_d = rx_next;
        if (bit_cnt_q == CNT_LAST) begin
          rd_data_d  = rx_next;
          latch_d    = 1'b1;
          rd_valid_d = 1'b1;
        end else begin
          // sreg_q[WIDTH-1] is on the wire now; present the next bit.
          sreg_d     = sreg_q << 1;
          sdo_d      = sreg_q[WIDTH-2];
          shift_en_d = 1'b1;
          bit_cnt_d  = bit_cnt_q + 1'b1;
        end
      end
      S_LATCH: gap_cnt_d = '0;
      S_GAP:   gap_cnt_d = gap_cnt_q + 1'b1;
      default: ;
    endcase
  end

  // Output decode: only ready/busy are combinational from state.
  always_comb begin
    load_ready = (state_q == S_IDLE);
    busy       = (state_q != S_IDLE);
  end

  assign sdo      = sdo_q;
  assign shift_en = shift_en_q;
  assign latch    = latch_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: doc/shift_chain_ctrl.md
Name: shift_chain_ctrl

Overview:
Frame controller for a serial chain of receptor capture stages. It accepts a parallel configuration word over a valid/ready handshake and shifts it MSB-first into the chain. It reads back the previous chain contents from the chain tail at the same time, then issues a one-cycle latch strobe. It supports two modes: static (one frame per request) and dynamic (the last word is re-sent continuously).

Parameters:
WIDTH, 16, chain length in stages = bits per frame (>=2)
GAP, 2, idle cycles inserted after LATCH before returning to IDLE (>=0)

Ports:
CLK  input  1  single clock, rising edge
RST  input  1  synchronous, active-high reset
load_valid  input  1  new word offered
load_ready  output  1  controller can accept a word (state==IDLE)
load_data  input  WIDTH  word to shift into chain
mode_dyn  input  1  0=static, 1=dynamic re-send; sampled only in IDLE
sdo  output  1  serial data to chain head
shift_en  output  1  chain stages advance this cycle
sdi  input  1  serial data from chain tail (combinationally valid each cycle)
latch  output  1  one-cycle update strobe to chain outputs
rd_data  output  WIDTH  readback of previous chain contents
rd_valid  output  1  one-cycle pulse, rd_data updated
busy  output  1  state != IDLE

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is synchronous and active-high. Every register clears on the CLK edge where RST=1.
- Reset values:
  - state=IDLE; sdo=0, shift_en=0, latch=0, rd_valid=0, rd_data=0, busy=0, load_ready=1.
  - Internal shift reg, rx reg, bit counter, gap counter and held word clear to 0.
  - have_word flag clears to 0.
- FSM states: IDLE, SHIFT, LATCH, GAP. All outputs are registered, except load_ready and busy, which decode directly from state.
- IDLE, priority order:
  - (1) load_valid=1 (handshake): capture load_data into the shift reg and the held word; set have_word=1; go to SHIFT.
  - (2) else if mode_dyn=1 and have_word=1: reload the held word into the shift reg; go to SHIFT.
  - (3) else stay in IDLE.
- SHIFT: lasts exactly WIDTH cycles.
  - shift_en=1 throughout.
  - Shift cycle k (0..WIDTH-1): sdo = word[WIDTH-1-k].
  - Each cycle: rx <= {rx[WIDTH-2:0], sdi}.
  - On the last cycle, rd_data <= {rx[WIDTH-2:0], sdi}; then go to LATCH.
- LATCH: one cycle. latch=1, rd_valid=1, shift_en=0, sdo=0. Go to GAP if GAP>0, else to IDLE.
- GAP: exactly GAP cycles with all strobes 0, then IDLE.
- Timing: handshake in cycle t.
  - SHIFT occupies t+1..t+WIDTH.
  - LATCH at t+WIDTH+1.
  - IDLE again at t+WIDTH+2+GAP.
  - Back-to-back frame period = WIDTH+GAP+2 cycles.
- Handshake: transfer occurs only when load_valid & load_ready in the same cycle. A word offered while busy is not consumed; the source holds it stable until load_ready. In IDLE a new word always overrides a dynamic re-send.
- mode_dyn changes outside IDLE have no effect on the frame in progress.
- Readback: with a WIDTH-stage chain, rd_data equals the chain contents present before the frame, MSB in rd_data[WIDTH-1].
- Bit counter: width $clog2(WIDTH). It must not wrap early; the SHIFT to LATCH transition happens at count WIDTH-1.
- Reset mid-frame (any state): next cycle is IDLE with reset values.
  - latch does not pulse for the aborted frame.
  - have_word=0, so dynamic mode does not restart until a new word is loaded.
- RST and load_valid asserted together: reset wins and the word is not accepted.

Test Plan:
1. WIDTH=8, GAP=2. Reset, then load 0xA5 -> shift_en high for 8 cycles, sdo=1,0,1,0,0,1,0,1; latch and rd_valid pulse on cycle 9 after the handshake; load_ready=0 for 11 cycles.
2. Bench 8-flop chain model preloaded with 0x3C; load 0xA5 -> rd_data=0x3C with rd_valid. Then load 0x00 -> rd_data=0xA5 and chain holds 0x00.
3. mode_dyn=1 after loading 0x5A with no further loads -> frames of 0x5A repeat every 12 cycles. Offer 0x0F mid-frame -> accepted at the next IDLE, and the following frames carry 0x0F.
4. mode_dyn=0, single load 0x81 -> exactly one frame, then IDLE with shift_en=0 for 50 cycles; load_valid held during busy is consumed only once.
5. Assert RST during the 4th SHIFT cycle -> next cycle busy=0, shift_en=0, rd_data=0, no latch pulse. With mode_dyn=1, no frame starts until a new load.
6. Build with WIDTH=4, GAP=0 and continuous load_valid -> frames back-to-back with 6-cycle period; a latch pulse every 6 cycles.
